// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: push-button conditioning front end.
//
// This block takes a raw, asynchronous, bouncing button line and produces clean, registered
// button events in the clk domain.
//   - A two-flop synchroniser brings btn_in into the clk domain.
//   - A stability counter flips the debounced level only after STABLE_CYCLES consecutive
//     synchronised samples disagree with it.
//   - Each debounced rising edge gives a one-cycle btn_press; each falling edge gives a
//     one-cycle btn_release.
//
// Optional feature, enabled by defining DEBOUNCE_REPEAT_EN:
//   While the button is held, btn_press auto-repeats. The first repeat comes REPEAT_DELAY
//   cycles after the press pulse, then one every REPEAT_PERIOD cycles after that.
//   repeat_active is high while repeating. Without the macro, repeat_active is tied to 0.
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst_n         in   synchronous active-low reset
//   btn_in        in   raw button, asynchronous, active-high
//   btn_level     out  debounced level
//   btn_press     out  one-cycle pulse on debounced rise and on each auto-repeat
//   btn_release   out  one-cycle pulse on debounced fall
//   repeat_active out  high while auto-repeating
module btn_debounce_pulse #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic repeat_active
);

  if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gen_param_check
    $error("btn_debounce_pulse: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  // Count value on the cycle before the counter would reach STABLE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPressed = 2'd1;
`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [1:0] StRepeat  = 2'd2;
`endif

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic            press_d, release_d;
  logic            mismatch, flip;

  // Synchroniser. Only sync2_q is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Any agreement with the current level throws away all accumulated disagreement.
  assign mismatch = (sync2_q != btn_level);
  assign flip     = mismatch && (cnt_q == CntLast);

  always_comb begin
    cnt_d = '0;
    if (mismatch && !flip) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned TmrMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD - 1);
  localparam logic [TmrW-1:0] TmrSat     = TmrW'(TmrMax);

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            delay_hit, period_hit;

  // A hit means the timer reaches its target on this edge.
  assign delay_hit  = (state_q == StPressed) && (tmr_q == DelayLast);
  assign period_hit = (state_q == StRepeat) && (tmr_q == PeriodLast);
`endif

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (flip) begin
          state_d = StPressed;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        // A fall takes priority over a coincident repeat expiry.
        if (flip) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end
`ifdef DEBOUNCE_REPEAT_EN
        else if (delay_hit) begin
          state_d = StRepeat;
          press_d = 1'b1;
        end
`endif
      end
`ifdef DEBOUNCE_REPEAT_EN
      StRepeat: begin
        if (flip) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (period_hit) begin
          press_d = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef DEBOUNCE_REPEAT_EN
  // Cleared on every state entry and on every repeat pulse. Saturates instead of wrapping.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == StIdle || state_d != state_q || press_d) begin
      tmr_d = '0;
    end else if (tmr_q != TmrSat) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q         <= '0;
      repeat_active <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      repeat_active <= (state_d == StRepeat);
    end
  end
`else
  assign repeat_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= StIdle;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      // The level is high exactly when the FSM is out of IDLE.
      btn_level   <= (state_d != StIdle);
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse (STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=4).
//
// The reference model works on edge-indexed sample history:
//   - A flip happens when the last STABLE_CYCLES visible samples all differ from the level.
//   - Repeats are timed by edge distance from the previous press.
//
// The outputs are compared against the model every cycle. Literal edge offsets then pin the
// model itself.
module tb_btn_debounce_pulse;
  localparam int S  = 4;
  localparam int RD = 10;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, repeat_active;

  btn_debounce_pulse #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .repeat_active(repeat_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_n = -1;

  bit raw[$];    // value loaded into the first sync stage at each edge
  bit diffs[$];  // last S visible samples: did each differ from the level?
  bit m_level = 1'b0;
  bit m_press = 1'b0;
  bit m_release = 1'b0;
  bit m_rep = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
  int m_last_press = 0;
`endif

  int press_edges[$];
  int release_edges[$];

  task automatic model_edge(input bit b, input bit r);
    bit seen;
    bit all_diff;
    edge_n++;
    seen = (raw.size() >= 2) ? raw[raw.size()-2] : 1'b0;
    raw.push_back(r ? b : 1'b0);
    m_press = 1'b0;
    m_release = 1'b0;
    if (!r) begin
      m_level = 1'b0;
      m_rep = 1'b0;
      diffs.delete();
    end else begin
      diffs.push_back(seen != m_level);
      if (diffs.size() > S) void'(diffs.pop_front());
      all_diff = (diffs.size() == S);
      foreach (diffs[i]) if (!diffs[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_level = !m_level;
        diffs.delete();
        if (m_level) begin
          m_press = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
          m_last_press = edge_n;
`endif
        end else begin
          m_release = 1'b1;
          m_rep = 1'b0;
        end
      end
`ifdef DEBOUNCE_REPEAT_EN
      else if (m_level) begin
        if ((!m_rep && edge_n - m_last_press == RD) || (m_rep && edge_n - m_last_press == RP)) begin
          m_press = 1'b1;
          m_rep = 1'b1;
          m_last_press = edge_n;
        end
      end
`endif
    end
  endtask

  task automatic check_cycle();
    logic [3:0] got, exp;
    got = {btn_level, btn_press, btn_release, repeat_active};
    exp = {m_level, m_press, m_release, m_rep};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL cycle edge %0d: got lvl/prs/rel/rep=%b, expected %b", edge_n, got, exp);
    end
    total++;
    if (btn_press && btn_release) begin
      bad++;
      $display("FAIL exclusive edge %0d: press and release both 1, expected not both", edge_n);
    end
    if (btn_press === 1'b1) press_edges.push_back(edge_n);
    if (btn_release === 1'b1) release_edges.push_back(edge_n);
  endtask

  task automatic step(input bit b, input bit r);
    btn_in = b;
    rst_n = r;
    @(posedge clk);
    model_edge(b, r);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic hold(input bit b, input bit r, input int n);
    for (int i = 0; i < n; i++) step(b, r);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int first_or(input int q[$], input int base);
    return (q.size() > 0) ? q[0] - base : -1;
  endfunction

  initial begin
    int e0;
    int p;

    // Reset.
    hold(0, 0, 3);
    check_int("reset outputs", int'({btn_level, btn_press, btn_release, repeat_active}), 0);
    hold(0, 1, 5);

    // Clean press: press lands on edge S+1 counting the first sampling edge as edge 0.
    press_edges.delete();
    release_edges.delete();
    e0 = edge_n + 1;
    hold(1, 1, 12);
    check_int("clean press count", press_edges.size(), 1);
    check_int("clean press latency", first_or(press_edges, e0), 5);
    check_int("clean level", int'(btn_level), 1);
    e0 = edge_n + 1;
    hold(0, 1, 12);
    check_int("clean release count", release_edges.size(), 1);
    check_int("clean release latency", first_or(release_edges, e0), 5);
    check_int("clean no extra press", press_edges.size(), 1);

    // Bounce 1,0,1,1,0 then a steady 1: one press, 6th edge from the first steady sample.
    press_edges.delete();
    release_edges.delete();
    step(1, 1); step(0, 1); step(1, 1); step(1, 1); step(0, 1);
    e0 = edge_n + 1;
    hold(1, 1, 10);
    check_int("bounce press count", press_edges.size(), 1);
    check_int("bounce press latency", first_or(press_edges, e0), 5);
    hold(0, 1, 10);

    // Short glitch: three high samples never make it through.
    press_edges.delete();
    release_edges.delete();
    hold(1, 1, 3);
    hold(0, 1, 10);
    check_int("glitch press count", press_edges.size(), 0);
    check_int("glitch release count", release_edges.size(), 0);
    check_int("glitch level", int'(btn_level), 0);

    // Reset while held: outputs clear, then a fresh press follows.
    hold(1, 1, 8);
    check_int("pre-reset level", int'(btn_level), 1);
    step(1, 0);
    check_int("in-reset outputs 1", int'({btn_level, btn_press, btn_release, repeat_active}), 0);
    step(1, 0);
    check_int("in-reset outputs 2", int'({btn_level, btn_press, btn_release, repeat_active}), 0);
    press_edges.delete();
    release_edges.delete();
    e0 = edge_n + 1;
    hold(1, 1, 10);
    check_int("post-reset press count", press_edges.size(), 1);
    check_int("post-reset press latency", first_or(press_edges, e0), 5);
    hold(0, 1, 10);

`ifdef DEBOUNCE_REPEAT_EN
    // Auto-repeat: presses at P, P+10, P+14, ... while held to P+30.
    press_edges.delete();
    release_edges.delete();
    p = edge_n + 1 + 5;
    hold(1, 1, 36);
    check_int("repeat press count", press_edges.size(), 7);
    for (int k = 0; k < 7; k++) begin
      check_int("repeat press offset", (press_edges.size() > k) ? press_edges[k] - p : -1,
                (k == 0) ? 0 : 6 + 4 * k);
    end
    check_int("repeat active", int'(repeat_active), 1);
    hold(0, 1, 10);
    check_int("repeat release count", release_edges.size(), 1);
    check_int("repeat active after release", int'(repeat_active), 0);

    // Release lands exactly on the P+14 repeat expiry: release only.
    press_edges.delete();
    release_edges.delete();
    p = edge_n + 1 + 5;
    hold(1, 1, 14);
    hold(0, 1, 10);
    check_int("collision press count", press_edges.size(), 2);
    check_int("collision release count", release_edges.size(), 1);
    check_int("collision release offset", first_or(release_edges, p), 14);
`else
    // Without repeat, a long hold gives a single press.
    press_edges.delete();
    release_edges.delete();
    p = edge_n + 1 + 5;
    hold(1, 1, 40);
    check_int("long hold press count", press_edges.size(), 1);
    check_int("long hold press offset", first_or(press_edges, p), 0);
    check_int("long hold repeat_active", int'(repeat_active), 0);
    hold(0, 1, 10);
    check_int("long hold release count", release_edges.size(), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
